// File: rtl/gpio_input_debounce.sv
// rtl/gpio_input_debounce.sv - button/switch synchroniser, debouncer, edge events and press interrupt
module gpio_input_debounce #(
    parameter int N_BTN           = 4,
    parameter int N_SW            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_out,
    output logic [N_SW-1:0]  sw_out,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_change,
    input  logic [N_BTN-1:0] irq_mask,
    input  logic [N_BTN-1:0] irq_clear,
    output logic [N_BTN-1:0] irq_status,
    output logic             irq
);

    localparam int N = N_BTN + N_SW;
    // Buttons idle high (released), switches idle low; buttons occupy the low bits.
    localparam logic [N-1:0]     RST_VAL = {{N_SW{1'b0}}, {N_BTN{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     s;
    logic [N-1:0]     q;
    logic [N-1:0]     rise;
    logic [N-1:0]     fall;
    logic [CNT_W-1:0] cnt [N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RST_VAL;
        end else begin
            sync_q[0] <= {sw_raw, btn_raw};
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any sample that agrees with the stable value restarts that bit's count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= RST_VAL;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                rise[i] <= 1'b0;
                fall[i] <= 1'b0;
                if (s[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i]  <= '0;
                    q[i]    <= s[i];
                    rise[i] <= s[i];
                    fall[i] <= ~s[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_out     = q[N_BTN-1:0];
    assign sw_out      = q[N-1:N_BTN];
    assign btn_press   = fall[N_BTN-1:0];
    assign btn_release = rise[N_BTN-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_change  <= '0;
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            sw_change  <= '0;
            for (int j = 0; j < N_SW; j++) begin
                if (s[N_BTN+j] != q[N_BTN+j] && cnt[N_BTN+j] == CNT_MAX) sw_change[j] <= 1'b1;
            end
            // A press arriving with a clear on the same edge keeps the flag set.
            irq_status <= (irq_status & ~irq_clear) | btn_press;
            irq        <= |(irq_status & irq_mask);
        end
    end

endmodule

// File: tb/tb_gpio_input_debounce.sv
// tb/tb_gpio_input_debounce.sv - randomized and directed checks against a sliding-window model
module tb_gpio_input_debounce;

    localparam int SS = 2;
    localparam int D  = 8;
    localparam int HL = SS + D;
    localparam logic [7:0] RST = 8'h0F;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] sw_raw = 4'h0;
    logic [3:0] btn_out, btn_press, btn_release, irq_status;
    logic [3:0] sw_out, sw_change;
    logic [3:0] irq_mask = 4'h0;
    logic [3:0] irq_clear = 4'h0;
    logic       irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] hist [$];
    logic [7:0] m_q;
    logic [3:0] m_press, m_rel, m_chg, m_status;
    logic       m_irq;

    always #5 clk = ~clk;

    gpio_input_debounce #(
        .N_BTN(4), .N_SW(4), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .btn_out(btn_out), .sw_out(sw_out), .btn_press(btn_press),
        .btn_release(btn_release), .sw_change(sw_change), .irq_mask(irq_mask),
        .irq_clear(irq_clear), .irq_status(irq_status), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A stable level flips only when the last D synchronised samples all disagree with it.
    task automatic model_edge();
        logic [7:0] flip;
        bit ok;
        if (reset) begin
            hist.delete();
            repeat (HL) hist.push_back(RST);
            m_q = RST; m_press = 0; m_rel = 0; m_chg = 0; m_status = 0; m_irq = 0;
            return;
        end
        hist.push_front({sw_raw, btn_raw});
        void'(hist.pop_back());
        flip = '0;
        for (int b = 0; b < 8; b++) begin
            ok = 1;
            for (int k = SS; k < HL; k++) if (hist[k][b] == m_q[b]) ok = 0;
            flip[b] = ok;
        end
        m_irq    = |(m_status & irq_mask);
        m_status = (m_status & ~irq_clear) | m_press;
        m_press  = flip[3:0] & m_q[3:0];
        m_rel    = flip[3:0] & ~m_q[3:0];
        m_chg    = flip[7:4];
        m_q      = m_q ^ flip;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("btn_out", btn_out, m_q[3:0]);
        check("sw_out", sw_out, m_q[7:4]);
        check("btn_press", btn_press, m_press);
        check("btn_release", btn_release, m_rel);
        check("sw_change", sw_change, m_chg);
        check("irq_status", irq_status, m_status);
        check("irq", irq, m_irq);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        check("rst_btn_out", btn_out, 4'hF);
        check("rst_sw_out", sw_out, 4'h0);
        check("rst_events", {btn_press, btn_release, sw_change}, 12'h000);
        check("rst_irq", {irq_status, irq}, 5'h00);
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] acc;
        int pulses;

        repeat (3) step();
        check("reset_btn_out", btn_out, 4'hF);
        check("reset_sw_out", sw_out, 4'h0);
        check("reset_irq", irq, 1'b0);
        reset = 1'b0;
        repeat (3) step();

        // Single button press: level and pulse on edge 9, status on edge 10.
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 8) check("t1_out_e8", btn_out[0], 1'b1);
            if (i == 9) check("t1_out_e9", btn_out[0], 1'b0);
            if (i == 9) check("t1_press_e9", btn_press[0], 1'b1);
            if (i == 10) check("t1_press_e10", btn_press[0], 1'b0);
            if (i == 9) check("t1_stat_e9", irq_status[0], 1'b0);
            if (i == 10) check("t1_stat_e10", irq_status[0], 1'b1);
        end
        btn_raw[0] = 1'b1;
        irq_clear = 4'hF;
        step();
        irq_clear = 4'h0;
        repeat (12) step();

        // Glitches of D-1 synchronised cycles never pass.
        acc = 0;
        for (int r = 0; r < 5; r++) begin
            btn_raw[1] = 1'b0;
            repeat (7) begin step(); acc |= btn_press | btn_release; end
            btn_raw[1] = 1'b1;
            step(); acc |= btn_press | btn_release;
        end
        repeat (4) begin step(); acc |= btn_press | btn_release | sw_change; end
        check("t2_no_events", acc, 4'h0);
        check("t2_out", btn_out[1], 1'b1);

        // Masked interrupt with buttons 0 and 2.
        irq_mask = 4'b0001;
        btn_raw = 4'b1010;
        repeat (13) step();
        check("t3_status", irq_status, 4'b0101);
        check("t3_irq", irq, 1'b1);
        irq_clear = 4'b0001;
        step();
        irq_clear = 4'b0000;
        check("t3_status_clr", irq_status, 4'b0100);
        check("t3_irq_lag", irq, 1'b1);
        step();
        check("t3_irq_off", irq, 1'b0);
        check("t3_status_keep", irq_status, 4'b0100);
        btn_raw = 4'hF;
        repeat (12) step();

        // Clear coinciding with the press pulse: set wins.
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("t4_press", btn_press[0], 1'b1);
        irq_clear = 4'b0001;
        step();
        irq_clear = 4'b0000;
        check("t4_set_wins", irq_status[0], 1'b1);
        btn_raw[0] = 1'b1;
        repeat (12) step();

        // All switches together, then switch 2 alone.
        sw_raw = 4'hF;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 9) check("t5_sw_out", sw_out, 4'hF);
            if (i == 9) check("t5_change", sw_change, 4'hF);
            if (i == 10) check("t5_change_off", sw_change, 4'h0);
        end
        sw_raw[2] = 1'b0;
        acc = 0;
        repeat (12) begin step(); acc |= sw_change; end
        check("t5_sw2_only", acc, 4'b0100);

        // Reset in the middle of a debounce.
        btn_raw[3] = 1'b0;
        repeat (5) step();
        do_reset(2);
        check("t6_out_held", btn_out[3], 1'b1);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (btn_press[3]) pulses++;
            if (i == 8) check("t6_press_e8", btn_press[3], 1'b0);
            if (i == 9) check("t6_press_e9", btn_press[3], 1'b1);
        end
        check("t6_one_press", pulses, 1);
        btn_raw = 4'hF;
        repeat (12) step();

        // Random phase: sparse bit flips give a mix of glitches and real transitions.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
                if ($urandom_range(0, 9) == 0) sw_raw[b] = ~sw_raw[b];
            end
            irq_clear = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 99) == 0) irq_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 699) == 0) do_reset($urandom_range(1, 3));
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
